// File: rtl/up_down_counter.sv
// W-bit synchronous up/down counter with synchronous clear, count enable
// and a combinational end-of-count flag for cascading.
module up_down_counter #(
    parameter int W = 4
) (
    input  logic         ck,
    input  logic         cl,
    input  logic         en,
    input  logic         ud,
    output logic [W-1:0] q,
    output logic         c
);

    localparam logic [W-1:0] ONE = W'(1);

    // No asynchronous reset: q is undefined until the first clear.
    always_ff @(posedge ck) begin
        if (cl) begin
            q <= '0;
        end else if (en) begin
            if (ud) begin
                q <= q - ONE;
            end else begin
                q <= q + ONE;
            end
        end
    end

    // Flag is deliberately not gated by en, so stage n+1 can use en & c.
    assign c = ud ? (q == '0) : (q == '1);

endmodule

// File: tb/tb_up_down_counter.sv
// Directed self-checking bench for up_down_counter at W=4 and W=1.
module tb_up_down_counter;

    logic       ck;
    logic       cl, en, ud;
    logic [3:0] q;
    logic       c;
    logic       cl1, en1, ud1;
    logic [0:0] q1;
    logic       c1;

    int checks;
    int errors;

    up_down_counter #(4) dut (
        .ck(ck), .cl(cl), .en(en), .ud(ud), .q(q), .c(c)
    );

    up_down_counter #(1) dut1 (
        .ck(ck), .cl(cl1), .en(en1), .ud(ud1), .q(q1), .c(c1)
    );

    initial ck = 1'b0;
    always #10 ck = ~ck;

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic drive_and_clock(input logic cl_v, input logic en_v, input logic ud_v);
        @(negedge ck);
        cl = cl_v;
        en = en_v;
        ud = ud_v;
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        drive_and_clock(1'b1, 1'b0, 1'b0);
        checks++;
        if (q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_q got %0d expected 0", q);
        end
        checks++;
        if (c !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_c got %b expected 0", c);
        end
    endtask

    task automatic test_up_count();
        logic [3:0] exp_q;
        logic       exp_c;
        exp_q = 4'd0;
        for (int i = 0; i < 20; i++) begin
            drive_and_clock(1'b0, 1'b1, 1'b0);
            exp_q = exp_q + 4'd1;
            exp_c = (exp_q == 4'd15);
            checks++;
            if (q !== exp_q) begin
                errors++;
                $display("[TB] FAIL up_q step %0d got %0d expected %0d", i, q, exp_q);
            end
            checks++;
            if (c !== exp_c) begin
                errors++;
                $display("[TB] FAIL up_c step %0d got %b expected %b", i, c, exp_c);
            end
        end
    endtask

    task automatic test_down_count();
        logic [3:0] exp_seq [8] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12};
        logic       exp_c;
        for (int i = 0; i < 8; i++) begin
            drive_and_clock(1'b0, 1'b1, 1'b1);
            exp_c = (exp_seq[i] == 4'd0);
            checks++;
            if (q !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL down_q step %0d got %0d expected %0d", i, q, exp_seq[i]);
            end
            checks++;
            if (c !== exp_c) begin
                errors++;
                $display("[TB] FAIL down_c step %0d got %b expected %b", i, c, exp_c);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 2; i++) begin
            drive_and_clock(1'b0, 1'b0, 1'b0);
            checks++;
            if (q !== 4'd12) begin
                errors++;
                $display("[TB] FAIL hold_q cycle %0d got %0d expected 12", i, q);
            end
        end
    endtask

    task automatic test_clear_priority();
        drive_and_clock(1'b1, 1'b1, 1'b1);
        checks++;
        if (q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL clear_prio_q got %0d expected 0", q);
        end
        drive_and_clock(1'b0, 1'b0, 1'b1);
        checks++;
        if (q !== 4'd0) begin
            errors++;
            $display("[TB] FAIL clear_hold_q got %0d expected 0", q);
        end
    endtask

    // ud toggles between edges while holding at q=0; only c should react.
    task automatic test_ud_toggle();
        logic exp_c;
        @(negedge ck);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ud = i[0];
            exp_c = i[0];
            #2;
            checks++;
            if (c !== exp_c) begin
                errors++;
                $display("[TB] FAIL ud_toggle_c step %0d got %b expected %b", i, c, exp_c);
            end
            checks++;
            if (q !== 4'd0) begin
                errors++;
                $display("[TB] FAIL ud_toggle_q step %0d got %0d expected 0", i, q);
            end
        end
    endtask

    // Direction flips on consecutive enabled edges with no dead cycle.
    task automatic test_back_to_back();
        logic [3:0] exp_seq [4] = '{4'd1, 4'd0, 4'd15, 4'd0};
        logic       ud_seq  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_and_clock(1'b0, 1'b1, ud_seq[i]);
            checks++;
            if (q !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL b2b_q step %0d got %0d expected %0d", i, q, exp_seq[i]);
            end
        end
    endtask

    task automatic test_width_one();
        logic [0:0] exp_q;
        @(negedge ck);
        cl1 = 1'b1;
        en1 = 1'b1;
        ud1 = 1'b0;
        @(posedge ck);
        #1;
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1_clear_q got %b expected 0", q1);
        end
        exp_q = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            cl1 = 1'b0;
            @(posedge ck);
            #1;
            exp_q = ~exp_q;
            checks++;
            if (q1 !== exp_q) begin
                errors++;
                $display("[TB] FAIL w1_q step %0d got %b expected %b", i, q1, exp_q);
            end
            checks++;
            if (c1 !== exp_q[0]) begin
                errors++;
                $display("[TB] FAIL w1_c step %0d got %b expected %b", i, c1, exp_q[0]);
            end
        end
        @(negedge ck);
        en1 = 1'b0;
        ud1 = 1'b1;
        #1;
        checks++;
        if (c1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w1_down_c got %b expected 1", c1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cl  = 1'b0;
        en  = 1'b0;
        ud  = 1'b0;
        cl1 = 1'b0;
        en1 = 1'b0;
        ud1 = 1'b0;
        test_reset();
        test_up_count();
        test_down_count();
        test_hold();
        test_clear_priority();
        test_ud_toggle();
        test_back_to_back();
        test_width_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
